// File: rtl/imm_encoder.sv
// RV32I immediate packer: scatters a 32-bit immediate into the I/S/B/U/J fields of a base
// instruction word through a two-stage valid/ready pipeline with range checking and error accounting.
module imm_encoder #(
    parameter int unsigned ERR_CNT_W   = 8,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_type,
    input  logic [31:0]          imm_val,
    input  logic [31:0]          base_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 3;

    localparam logic [TYPE_W-1:0] TYPE_R = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_I = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_S = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_B = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] TYPE_U = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] TYPE_J = TYPE_W'(5);

    logic              s1_v;
    logic [TYPE_W-1:0] s1_type;
    logic [XLEN-1:0]   s1_imm;
    logic [XLEN-1:0]   s1_base;

    logic [XLEN-1:0]   enc_instr;
    logic              enc_err;
    logic              bad_type;
    logic              rng_err;

    logic              in_fire;
    logic              s2_adv;
    logic              err_handoff;

    // Stage 2 can take a new beat when it is empty or its current beat leaves this cycle.
    assign s2_adv      = !out_valid || out_ready;
    assign in_ready    = !s1_v || s2_adv;
    assign in_fire     = in_valid && in_ready;
    assign err_handoff = out_valid && out_ready && out_err;

    // Field scatter and representability check on the stage-1 beat.
    always_comb begin
        enc_instr = s1_base;
        bad_type  = 1'b0;
        rng_err   = 1'b0;
        case (s1_type)
            TYPE_R: begin
            end
            TYPE_I: begin
                enc_instr[31:20] = s1_imm[11:0];
                rng_err          = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            TYPE_S: begin
                enc_instr[31:25] = s1_imm[11:5];
                enc_instr[11:7]  = s1_imm[4:0];
                rng_err          = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            TYPE_B: begin
                enc_instr[31]    = s1_imm[12];
                enc_instr[30:25] = s1_imm[10:5];
                enc_instr[11:8]  = s1_imm[4:1];
                enc_instr[7]     = s1_imm[11];
                rng_err          = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
            end
            TYPE_U: begin
                enc_instr[31:12] = s1_imm[31:12];
                rng_err          = |s1_imm[11:0];
            end
            TYPE_J: begin
                enc_instr[31]    = s1_imm[20];
                enc_instr[30:21] = s1_imm[10:1];
                enc_instr[20]    = s1_imm[11];
                enc_instr[19:12] = s1_imm[19:12];
                rng_err          = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
            end
            default: begin
                bad_type = 1'b1;
            end
        endcase
    end

    assign enc_err = bad_type || (CHECK_RANGE && rng_err);

    // Pipeline registers; stage 2 is the output register and holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_type   <= '0;
            s1_imm    <= '0;
            s1_base   <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_v    <= 1'b1;
                s1_type <= imm_type;
                s1_imm  <= imm_val;
                s1_base <= base_instr;
            end else if (s2_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_instr <= enc_instr;
                    out_err   <= enc_err;
                end
            end
        end
    end

    // Error accounting at handoff; a clear in the same cycle still counts the handoff.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_cnt    <= err_handoff ? ERR_CNT_W'(1) : '0;
            err_sticky <= err_handoff;
        end else if (err_handoff) begin
            err_sticky <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, range/illegal errors, backpressure, reset and a
// randomized scoreboard against an arithmetic reference model.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] imm_val;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        clr_err;
    logic [7:0]  err_cnt;
    logic        err_sticky;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [31:0] out_instr_b;
    logic        out_err_b;
    logic [1:0]  err_cnt_b;
    logic        err_sticky_b;

    int n_tests = 0;
    int n_fail  = 0;

    imm_encoder #(.ERR_CNT_W(8), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .imm_val(imm_val), .base_instr(base_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .clr_err(clr_err), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    // Second instance: narrow saturating counter and no range checking.
    imm_encoder #(.ERR_CNT_W(2), .CHECK_RANGE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .imm_type(imm_type), .imm_val(imm_val), .base_instr(base_instr),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
        .out_err(out_err_b), .clr_err(clr_err), .err_cnt(err_cnt_b), .err_sticky(err_sticky_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: field masks and shifts, range decided on the signed value.
    function automatic void model(input logic [2:0] t, input logic [31:0] imm,
                                  input logic [31:0] base, input bit chk,
                                  output logic [31:0] instr, output logic err);
        int v;
        v = $signed(imm);
        err = 1'b0;
        case (t)
            3'd0: instr = base;
            3'd1: begin
                instr = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                err   = chk && (v < -2048 || v > 2047);
            end
            3'd2: begin
                instr = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                err   = chk && (v < -2048 || v > 2047);
            end
            3'd3: begin
                instr = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 32'h1) << 7);
                err   = chk && (v < -4096 || v > 4095 || (imm & 32'h1) != 0);
            end
            3'd4: begin
                instr = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
                err   = chk && ((imm & 32'hFFF) != 0);
            end
            3'd5: begin
                instr = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                      | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                      | (imm & 32'h000F_F000);
                err   = chk && (v < -(1 << 20) || v > (1 << 20) - 1 || (imm & 32'h1) != 0);
            end
            default: begin
                instr = base;
                err   = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r = 32'($signed(r) >>> $urandom_range(10, 31));
        if ($urandom_range(0, 1) != 0) r = r & 32'hFFFF_FFFE;
        if ($urandom_range(0, 5) == 0) r = r & 32'hFFFF_F000;
        return r;
    endfunction

    // Single beat through an empty pipeline with out_ready=1; returns the beat seen at the output.
    task automatic run_one(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                           input bit clr_h, output logic [31:0] instr, output logic err,
                           output bit got, output int lat);
        in_valid = 1'b1; imm_type = t; imm_val = imm; base_instr = base;
        tick();
        in_valid = 1'b0;
        got = 1'b0; lat = 1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        instr = out_instr;
        err   = out_err;
        clr_err = clr_h;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        imm_type = '0; imm_val = '0; base_instr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        n_tests++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_state cnt=%0d sticky=%0b exp 0/0", err_cnt, err_sticky); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  t  [5] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4};
        logic [31:0] im [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h8, 32'h1234_5000, 32'h1234_5001};
        logic [31:0] bs [5] = '{32'h13, 32'h63, 32'h6F, 32'h37, 32'h37};
        logic [31:0] ei [5] = '{32'hFFF0_0013, 32'hFE00_0EE3, 32'h0080_006F, 32'h1234_5037, 32'h1234_5037};
        logic        ee [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] instr;
        logic        err;
        bit          got;
        int          lat;
        for (int k = 0; k < 5; k++) begin
            run_one(t[k], im[k], bs[k], 1'b0, instr, err, got, lat);
            n_tests++; if (!got) begin n_fail++; $display("FAIL directed%0d_timeout no out_valid", k); end
            n_tests++; if (instr !== ei[k] || err !== ee[k]) begin n_fail++; $display("FAIL directed%0d got=%h/%0b exp=%h/%0b", k, instr, err, ei[k], ee[k]); end
            if (k == 0) begin
                n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL latency got=%0d exp=2", lat); end
            end
        end
    endtask

    task automatic test_range_err();
        logic [31:0] instr;
        logic        err;
        bit          got;
        int          lat;
        clear_errors();
        n_tests++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_initial cnt=%0d sticky=%0b exp 0/0", err_cnt, err_sticky); end
        run_one(3'd1, 32'h800, 32'h13, 1'b0, instr, err, got, lat);
        n_tests++; if (!got || err !== 1'b1 || instr !== 32'h8000_0013) begin n_fail++; $display("FAIL range_i got=%h/%0b exp=80000013/1", instr, err); end
        n_tests++; if (err_cnt !== 8'd1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL range_count cnt=%0d sticky=%0b exp 1/1", err_cnt, err_sticky); end
        clear_errors();
        n_tests++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_err cnt=%0d sticky=%0b exp 0/0", err_cnt, err_sticky); end
        run_one(3'd1, 32'h800, 32'h13, 1'b0, instr, err, got, lat);
        run_one(3'd1, 32'h800, 32'h13, 1'b1, instr, err, got, lat);
        n_tests++; if (err_cnt !== 8'd1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_same_cycle cnt=%0d sticky=%0b exp 1/1", err_cnt, err_sticky); end
    endtask

    task automatic test_illegal();
        logic [31:0] instr;
        logic        err;
        bit          got;
        int          lat;
        logic [31:0] base;
        base = $urandom;
        run_one(3'd7, 32'h7FFF_FFFF, base, 1'b0, instr, err, got, lat);
        n_tests++; if (!got || instr !== base || err !== 1'b1) begin n_fail++; $display("FAIL illegal_type got=%h/%0b exp=%h/1", instr, err, base); end
        base = $urandom;
        run_one(3'd0, 32'h8765_4321, base, 1'b0, instr, err, got, lat);
        n_tests++; if (!got || instr !== base || err !== 1'b0) begin n_fail++; $display("FAIL r_type got=%h/%0b exp=%h/0", instr, err, base); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t  [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [31:0] im [4] = '{32'h7FF, 32'hFFFF_F800, 32'h0000_0FFE, 32'hFFF0_0000};
        logic [31:0] bs [4] = '{32'h0000_0093, 32'h0000_2023, 32'h0000_1063, 32'h0000_00EF};
        logic [31:0] ei;
        logic        ee;
        int sent = 0, recv = 0;
        bit saw_block = 1'b0;
        bit stall_prev = 1'b0;
        logic [32:0] held = '0;
        for (int c = 0; c < 30 && recv < 4; c++) begin
            in_valid = (sent < 4);
            if (sent < 4) begin imm_type = t[sent]; imm_val = im[sent]; base_instr = bs[sent]; end
            out_ready = (c >= 3);
            #1;
            if (stall_prev) begin
                n_tests++; if (!out_valid || {out_err, out_instr} !== held) begin n_fail++; $display("FAIL stall_hold c=%0d got=%0b/%h exp=1/%h", c, out_valid, {out_err, out_instr}, held); end
            end
            if (in_valid && !in_ready && !saw_block) begin
                saw_block = 1'b1;
                n_tests++; if (sent !== 2) begin n_fail++; $display("FAIL block_point accepted=%0d exp=2", sent); end
            end
            if (out_valid && out_ready) begin
                model(t[recv], im[recv], bs[recv], 1'b1, ei, ee);
                n_tests++; if (out_instr !== ei || out_err !== ee) begin n_fail++; $display("FAIL b2b_beat%0d got=%h/%0b exp=%h/%0b", recv, out_instr, out_err, ei, ee); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            held = {out_err, out_instr};
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++; if (!saw_block || recv !== 4) begin n_fail++; $display("FAIL b2b_complete block=%0b recv=%0d exp=1/4", saw_block, recv); end
    endtask

    task automatic test_random();
        logic [32:0] exp_q[$];
        logic [32:0] exp_b_q[$];
        logic [32:0] e, eb;
        logic [31:0] mi;
        logic        me;
        int mcnt = 0, mcnt_b = 0, bad = 0, checked = 0;
        bit stall_prev = 1'b0;
        logic [32:0] held = '0;
        clear_errors();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                imm_type   = 3'($urandom_range(0, 7));
                imm_val    = rand_imm();
                base_instr = $urandom;
                out_ready  = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (stall_prev && (!out_valid || {out_err, out_instr} !== held)) bad++;
            if (in_valid && in_ready) begin
                model(imm_type, imm_val, base_instr, 1'b1, mi, me);
                exp_q.push_back({me, mi});
                model(imm_type, imm_val, base_instr, 1'b0, mi, me);
                exp_b_q.push_back({me, mi});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++; $display("FAIL rand_extra_beat got=%h", out_instr);
                end else begin
                    e  = exp_q.pop_front();
                    eb = exp_b_q.pop_front();
                    checked++;
                    n_tests++; if ({out_err, out_instr} !== e) begin n_fail++; $display("FAIL rand_beat%0d got=%0b/%h exp=%0b/%h", checked, out_err, out_instr, e[32], e[31:0]); end
                    n_tests++; if ({out_err_b, out_instr_b} !== eb) begin n_fail++; $display("FAIL rand_norange%0d got=%0b/%h exp=%0b/%h", checked, out_err_b, out_instr_b, eb[32], eb[31:0]); end
                    if (e[32]) mcnt = (mcnt == 255) ? 255 : mcnt + 1;
                    if (eb[32]) mcnt_b = (mcnt_b == 3) ? 3 : mcnt_b + 1;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_err, out_instr};
            tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_stall_hold violations=%0d exp=0", bad); end
        n_tests++; if (exp_q.size() != 0 || checked < 50) begin n_fail++; $display("FAIL rand_drain left=%0d checked=%0d", exp_q.size(), checked); end
        n_tests++; if (err_cnt !== 8'(mcnt) || err_sticky !== (mcnt != 0)) begin n_fail++; $display("FAIL rand_err_cnt got=%0d/%0b exp=%0d/%0b", err_cnt, err_sticky, mcnt, mcnt != 0); end
        n_tests++; if (err_cnt_b !== 2'(mcnt_b)) begin n_fail++; $display("FAIL rand_err_cnt_narrow got=%0d exp=%0d", err_cnt_b, mcnt_b); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] instr;
        logic        err;
        bit          got;
        int          lat;
        int          ghost = 0;
        run_one(3'd6, 32'h0, 32'h13, 1'b0, instr, err, got, lat);
        n_tests++; if (err_cnt === 8'd0) begin n_fail++; $display("FAIL pre_reset_cnt got=0 exp=nonzero"); end
        out_ready = 1'b0;
        in_valid = 1'b1; imm_type = 3'd7; imm_val = $urandom; base_instr = $urandom;
        tick();
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL pipe_full valid=%0b ready=%0b exp=1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_tests++; if (out_valid !== 1'b0 || err_cnt !== 8'd0 || err_sticky !== 1'b0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL mid_reset valid=%0b cnt=%0d sticky=%0b instr=%h exp 0/0/0/0", out_valid, err_cnt, err_sticky, out_instr); end
        for (int i = 0; i < 4; i++) begin
            if (out_valid) ghost++;
            tick();
        end
        n_tests++; if (ghost != 0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_ghost beats=%0d cnt=%0d exp=0/0", ghost, err_cnt); end
    endtask

    task automatic test_saturate();
        logic [31:0] instr;
        logic        err;
        bit          got;
        int          lat;
        for (int k = 0; k < 5; k++) begin
            run_one(3'd6, $urandom, $urandom, 1'b0, instr, err, got, lat);
        end
        n_tests++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL wide_cnt got=%0d exp=5", err_cnt); end
        n_tests++; if (err_cnt_b !== 2'd3 || err_sticky_b !== 1'b1) begin n_fail++; $display("FAIL narrow_saturate got=%0d/%0b exp=3/1", err_cnt_b, err_sticky_b); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range_err();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
